// File: rtl/rib_arbiter_pkg.sv
// rib_arbiter_pkg: shared definitions for the RIB bus arbiter.
//   rib_state_e      : arbiter FSM states (IDLE / BUSY / RESP)
//   HOLD_ENABLE/...  : levels of hold_flag_rib_o
//   RST_ENABLE       : active level of the asynchronous reset
//   RIB_M_CORE_*     : fixed master indices of the core data and fetch ports
//   rr_next()        : round-robin pointer advance
package rib_arbiter_pkg;

  typedef enum logic [1:0] {
    RIB_IDLE = 2'd0,
    RIB_BUSY = 2'd1,
    RIB_RESP = 2'd2
  } rib_state_e;

  localparam logic HOLD_ENABLE  = 1'b1;
  localparam logic HOLD_DISABLE = 1'b0;
  localparam logic RST_ENABLE   = 1'b0;

  localparam int RIB_M_CORE_DATA  = 0;
  localparam int RIB_M_CORE_FETCH = 1;

  // Pointer for the next arbitration: the master after the one just served.
  function automatic int rr_next(input int owner, input int masters);
    return (owner + 1) % masters;
  endfunction

endpackage

// File: rtl/rib_arbiter_if.sv
// rib_arbiter_if: all bus signals around the arbiter.
//   m_*   : master-side request/response (flattened per master)
//   s_*   : single slave-side channel towards the address decoder
//   grant_o, hold_flag_rib_o : arbitration status
// Modports:
//   slave  : the arbiter's view (it is the slave of the requesting masters)
//   master : the environment's view (masters plus the downstream slave)
//
// Handshake: a master raises m_req_i[k] with we/addr/wdata stable and holds
// it until it sees m_ack_o[k] (one-cycle pulse); it drops the request in the
// cycle after the pulse. s_req_o is held with frozen s_* fields until the
// slave answers with a one-cycle s_ack_i (or the watchdog gives up).
interface rib_arbiter_if #(
  parameter int MASTERS = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [MASTERS-1:0]        m_req_i;
  logic [MASTERS-1:0]        m_we_i;
  logic [MASTERS*ADDR_W-1:0] m_addr_i;
  logic [MASTERS*DATA_W-1:0] m_wdata_i;
  logic [MASTERS-1:0]        m_ack_o;
  logic [MASTERS-1:0]        m_err_o;
  logic [DATA_W-1:0]         m_rdata_o;
  logic                      s_req_o;
  logic                      s_we_o;
  logic [ADDR_W-1:0]         s_addr_o;
  logic [DATA_W-1:0]         s_wdata_o;
  logic                      s_ack_i;
  logic [DATA_W-1:0]         s_rdata_i;
  logic [MASTERS-1:0]        grant_o;
  logic                      hold_flag_rib_o;

  modport slave (
    input  m_req_i, m_we_i, m_addr_i, m_wdata_i, s_ack_i, s_rdata_i,
    output m_ack_o, m_err_o, m_rdata_o, s_req_o, s_we_o, s_addr_o,
           s_wdata_o, grant_o, hold_flag_rib_o
  );

  modport master (
    output m_req_i, m_we_i, m_addr_i, m_wdata_i, s_ack_i, s_rdata_i,
    input  m_ack_o, m_err_o, m_rdata_o, s_req_o, s_we_o, s_addr_o,
           s_wdata_o, grant_o, hold_flag_rib_o
  );
endinterface

// File: rtl/rib_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req   : per-master request vector
//   ptr   : index with highest priority this round
//   grant : one-hot winner (0 when no request)
//   index : binary index of the winner
//   valid : some request is present
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index,
  output logic             valid
);

  logic [IDX_W-1:0] k;

  // Scan from ptr upward, wrapping; the first requester found wins.
  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      k = IDX_W'((int'(ptr) + i) % N);
      if (!valid && req[k]) begin
        valid    = 1'b1;
        index    = k;
        grant[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rib_arbiter.sv
// rib_arbiter: round-robin owner of the single RIB slave bus.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   bus     : rib_arbiter_if.slave (master requests, slave channel, grant,
//             hold flag towards the pipeline controller)
//   state_o : current FSM state, for observation
// One transaction per grant: IDLE picks a master, BUSY waits for the slave
// ack or the watchdog, RESP releases the grant and advances the pointer.
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int MASTERS = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  rib_arbiter_if.slave    bus,
  output rib_state_e      state_o
);

  localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  rib_state_e         state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [WD_W-1:0]    wd_cnt, wd_nxt;
  logic [MASTERS-1:0] grant_nxt, ack_nxt, err_nxt;
  logic               s_req_nxt, s_we_nxt;
  logic [ADDR_W-1:0]  s_addr_nxt;
  logic [DATA_W-1:0]  s_wdata_nxt, rdata_nxt;

  logic [MASTERS-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  rr_pick #(.N(MASTERS), .IDX_W(IDX_W)) u_rr_pick (
    .req   (bus.m_req_i),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .index (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    owner_nxt   = owner;
    wd_nxt      = wd_cnt;
    grant_nxt   = bus.grant_o;
    s_req_nxt   = bus.s_req_o;
    s_we_nxt    = bus.s_we_o;
    s_addr_nxt  = bus.s_addr_o;
    s_wdata_nxt = bus.s_wdata_o;
    rdata_nxt   = bus.m_rdata_o;
    ack_nxt     = '0;
    err_nxt     = '0;
    case (state)
      RIB_IDLE: begin
        if (pick_valid) begin
          state_nxt   = RIB_BUSY;
          owner_nxt   = pick_idx;
          grant_nxt   = pick_grant;
          s_req_nxt   = 1'b1;
          s_we_nxt    = bus.m_we_i[pick_idx];
          s_addr_nxt  = bus.m_addr_i[pick_idx*ADDR_W +: ADDR_W];
          s_wdata_nxt = bus.m_wdata_i[pick_idx*DATA_W +: DATA_W];
        end
      end
      RIB_BUSY: begin
        wd_nxt = wd_cnt + 1'b1;
        // A same-cycle ack beats the watchdog.
        if (bus.s_ack_i) begin
          state_nxt      = RIB_RESP;
          rdata_nxt      = bus.s_rdata_i;
          ack_nxt[owner] = 1'b1;
          s_req_nxt      = 1'b0;
        end else if (wd_cnt == WD_LAST) begin
          state_nxt      = RIB_RESP;
          rdata_nxt      = '0;
          ack_nxt[owner] = 1'b1;
          err_nxt[owner] = 1'b1;
          s_req_nxt      = 1'b0;
        end
      end
      RIB_RESP: begin
        state_nxt  = RIB_IDLE;
        grant_nxt  = '0;
        wd_nxt     = '0;
        rr_ptr_nxt = IDX_W'(rr_next(int'(owner), MASTERS));
      end
      default: state_nxt = RIB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state         <= RIB_IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      wd_cnt        <= '0;
      bus.grant_o   <= '0;
      bus.s_req_o   <= 1'b0;
      bus.s_we_o    <= 1'b0;
      bus.s_addr_o  <= '0;
      bus.s_wdata_o <= '0;
      bus.m_ack_o   <= '0;
      bus.m_err_o   <= '0;
      bus.m_rdata_o <= '0;
    end else begin
      state         <= state_nxt;
      rr_ptr        <= rr_ptr_nxt;
      owner         <= owner_nxt;
      wd_cnt        <= wd_nxt;
      bus.grant_o   <= grant_nxt;
      bus.s_req_o   <= s_req_nxt;
      bus.s_we_o    <= s_we_nxt;
      bus.s_addr_o  <= s_addr_nxt;
      bus.s_wdata_o <= s_wdata_nxt;
      bus.m_ack_o   <= ack_nxt;
      bus.m_err_o   <= err_nxt;
      bus.m_rdata_o <= rdata_nxt;
    end
  end

  // Core stalls while either of its ports waits for the bus; forced low in
  // reset so the pipeline is not held by a stale request.
  assign bus.hold_flag_rib_o = (rst == RST_ENABLE) ? HOLD_DISABLE :
    ((bus.m_req_i[RIB_M_CORE_DATA]  & ~bus.grant_o[RIB_M_CORE_DATA]) |
     (bus.m_req_i[RIB_M_CORE_FETCH] & ~bus.grant_o[RIB_M_CORE_FETCH]));

  assign state_o = state;

endmodule

// File: tb/tb_rib_arbiter.sv
module tb_rib_arbiter;
  import rib_arbiter_pkg::*;

  localparam int M  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic       clk;
  logic       rst;
  rib_state_e state;
  int         errors = 0;
  int         checks = 0;
  logic [M-1:0] exp_q[$];

  rib_arbiter_if #(.MASTERS(M), .ADDR_W(AW), .DATA_W(DW)) bus ();

  rib_arbiter #(.MASTERS(M), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m_req_i   = '0;
    bus.m_we_i    = '0;
    bus.m_addr_i  = '0;
    bus.m_wdata_i = '0;
    bus.s_ack_i   = 1'b0;
    bus.s_rdata_i = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  // ---------------- driver ----------------
  task automatic set_master(input int k, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata);
    bus.m_we_i[k]             = we;
    bus.m_addr_i[k*AW +: AW]  = addr;
    bus.m_wdata_i[k*DW +: DW] = wdata;
    bus.m_req_i[k]            = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    bus.m_req_i = 4'b1111;
    bus.s_ack_i = 1'b1;
    #1;
    checks++; if (bus.hold_flag_rib_o !== 1'b0) begin errors++; $display("FAIL reset_hold got=%b exp=0", bus.hold_flag_rib_o); end
    tick();
    checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", bus.grant_o); end
    checks++; if ({bus.s_req_o, bus.s_we_o} !== 2'b00) begin errors++; $display("FAIL reset_s_req_we got=%b exp=00", {bus.s_req_o, bus.s_we_o}); end
    checks++; if ({bus.s_addr_o, bus.s_wdata_o} !== 64'd0) begin errors++; $display("FAIL reset_s_addr_wdata got=%h exp=0", {bus.s_addr_o, bus.s_wdata_o}); end
    checks++; if ({bus.m_ack_o, bus.m_err_o} !== 8'd0) begin errors++; $display("FAIL reset_ack_err got=%b exp=0", {bus.m_ack_o, bus.m_err_o}); end
    checks++; if (bus.m_rdata_o !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.m_rdata_o); end
    checks++; if (state !== RIB_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state, RIB_IDLE); end
    apply_reset();
  endtask

  task automatic test_single_master();
    apply_reset();
    set_master(2, 1'b0, 32'h1000_0004, 32'h0);
    #1;
    checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL single_no_early_grant got=%b exp=0000", bus.grant_o); end
    tick(); // BUSY, first cycle
    checks++; if (bus.grant_o !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", bus.grant_o); end
    checks++; if ({bus.s_req_o, bus.s_we_o} !== 2'b10) begin errors++; $display("FAIL single_s_req_we got=%b exp=10", {bus.s_req_o, bus.s_we_o}); end
    checks++; if (bus.s_addr_o !== 32'h1000_0004) begin errors++; $display("FAIL single_s_addr got=%h exp=10000004", bus.s_addr_o); end
    tick();
    tick();
    tick();
    bus.s_ack_i   = 1'b1;
    bus.s_rdata_i = 32'hDEAD_BEEF;
    tick(); // RESP
    checks++; if (bus.m_ack_o !== 4'b0100) begin errors++; $display("FAIL single_ack got=%b exp=0100", bus.m_ack_o); end
    checks++; if (bus.m_err_o !== 4'b0000) begin errors++; $display("FAIL single_err got=%b exp=0000", bus.m_err_o); end
    checks++; if (bus.m_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata got=%h exp=deadbeef", bus.m_rdata_o); end
    checks++; if (bus.s_req_o !== 1'b0) begin errors++; $display("FAIL single_s_req_drop got=%b exp=0", bus.s_req_o); end
    bus.s_ack_i = 1'b0;
    bus.m_req_i = '0;
    tick(); // IDLE
    checks++; if ({bus.grant_o, bus.m_ack_o} !== 8'd0) begin errors++; $display("FAIL single_release got=%b exp=0", {bus.grant_o, bus.m_ack_o}); end
    checks++; if (state !== RIB_IDLE) begin errors++; $display("FAIL single_idle got=%0d exp=%0d", state, RIB_IDLE); end
  endtask

  task automatic test_round_robin();
    logic [M-1:0] exp;
    apply_reset();
    exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.m_req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick(); // BUSY
      exp = exp_q.pop_front();
      checks++; if (bus.grant_o !== exp) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, bus.grant_o, exp); end
      bus.s_ack_i   = 1'b1;
      bus.s_rdata_i = 32'h100 + i;
      tick(); // RESP
      checks++; if (bus.m_ack_o !== exp) begin errors++; $display("FAIL rr_ack[%0d] got=%b exp=%b", i, bus.m_ack_o, exp); end
      checks++; if (bus.m_rdata_o !== 32'h100 + i) begin errors++; $display("FAIL rr_rdata[%0d] got=%h exp=%h", i, bus.m_rdata_o, 32'h100 + i); end
      bus.s_ack_i = 1'b0;
      bus.m_req_i = bus.m_req_i & ~exp;
      tick(); // IDLE
      bus.m_req_i = 4'b1111;
    end
    bus.m_req_i = '0;
  endtask

  task automatic test_hold_flag();
    apply_reset();
    set_master(3, 1'b1, 32'h2000_0010, 32'h1234_5678);
    #1;
    checks++; if (bus.hold_flag_rib_o !== 1'b0) begin errors++; $display("FAIL hold_m3_only got=%b exp=0", bus.hold_flag_rib_o); end
    tick(); // BUSY, owner 3
    checks++; if (bus.grant_o !== 4'b1000) begin errors++; $display("FAIL hold_grant3 got=%b exp=1000", bus.grant_o); end
    checks++; if ({bus.s_we_o, bus.s_wdata_o} !== {1'b1, 32'h1234_5678}) begin errors++; $display("FAIL hold_s_we_wdata got=%h exp=112345678", {bus.s_we_o, bus.s_wdata_o}); end
    bus.m_addr_i[3*AW +: AW] = 32'hFFFF_FFFF;
    set_master(1, 1'b0, 32'h0000_0040, 32'h0);
    #1;
    checks++; if (bus.hold_flag_rib_o !== 1'b1) begin errors++; $display("FAIL hold_raise got=%b exp=1", bus.hold_flag_rib_o); end
    tick();
    checks++; if (bus.s_addr_o !== 32'h2000_0010) begin errors++; $display("FAIL hold_addr_frozen got=%h exp=20000010", bus.s_addr_o); end
    bus.s_ack_i = 1'b1;
    tick(); // RESP
    checks++; if ({bus.m_ack_o, bus.hold_flag_rib_o} !== 5'b10001) begin errors++; $display("FAIL hold_resp got=%b exp=10001", {bus.m_ack_o, bus.hold_flag_rib_o}); end
    bus.s_ack_i = 1'b0;
    bus.m_req_i[3] = 1'b0;
    tick(); // IDLE
    checks++; if ({bus.grant_o, bus.hold_flag_rib_o} !== 5'b00001) begin errors++; $display("FAIL hold_idle got=%b exp=00001", {bus.grant_o, bus.hold_flag_rib_o}); end
    tick(); // BUSY, owner 1
    checks++; if ({bus.grant_o, bus.hold_flag_rib_o} !== 5'b00100) begin errors++; $display("FAIL hold_grant1 got=%b exp=00100", {bus.grant_o, bus.hold_flag_rib_o}); end
    bus.s_ack_i = 1'b1;
    tick();
    bus.s_ack_i = 1'b0;
    bus.m_req_i = '0;
    tick();
  endtask

  task automatic test_ack_timeout_tie();
    apply_reset();
    set_master(0, 1'b0, 32'h3000_0000, 32'h0);
    tick(); // BUSY cycle 1
    for (int c = 2; c <= TO; c++) begin
      tick();
      checks++; if (bus.m_ack_o !== 4'b0000) begin errors++; $display("FAIL tie_early_ack[c%0d] got=%b exp=0000", c, bus.m_ack_o); end
    end
    bus.s_ack_i   = 1'b1; // last watchdog cycle
    bus.s_rdata_i = 32'hA5A5_5A5A;
    tick(); // RESP
    checks++; if ({bus.m_ack_o, bus.m_err_o} !== 8'b0001_0000) begin errors++; $display("FAIL tie_ack_err got=%b exp=00010000", {bus.m_ack_o, bus.m_err_o}); end
    checks++; if (bus.m_rdata_o !== 32'hA5A5_5A5A) begin errors++; $display("FAIL tie_rdata got=%h exp=a5a55a5a", bus.m_rdata_o); end
    bus.s_ack_i = 1'b0;
    bus.m_req_i = '0;
    tick();
  endtask

  // Runs straight after the tie test: rr_ptr = 1 and m_rdata_o is non-zero.
  task automatic test_timeout();
    set_master(1, 1'b0, 32'h4000_0000, 32'h0);
    tick(); // BUSY cycle 1
    checks++; if (bus.grant_o !== 4'b0010) begin errors++; $display("FAIL to_grant got=%b exp=0010", bus.grant_o); end
    for (int c = 2; c <= TO; c++) begin
      tick();
      checks++; if ({bus.m_ack_o, bus.m_err_o} !== 8'd0) begin errors++; $display("FAIL to_early[c%0d] got=%b exp=0", c, {bus.m_ack_o, bus.m_err_o}); end
    end
    tick(); // RESP after exactly TO BUSY cycles
    checks++; if ({bus.m_ack_o, bus.m_err_o} !== 8'b0010_0010) begin errors++; $display("FAIL to_ack_err got=%b exp=00100010", {bus.m_ack_o, bus.m_err_o}); end
    checks++; if (bus.m_rdata_o !== 32'd0) begin errors++; $display("FAIL to_rdata got=%h exp=0", bus.m_rdata_o); end
    checks++; if (bus.s_req_o !== 1'b0) begin errors++; $display("FAIL to_s_req got=%b exp=0", bus.s_req_o); end
    bus.m_req_i = '0;
    tick();
    checks++; if ({bus.m_ack_o, bus.m_err_o} !== 8'd0) begin errors++; $display("FAIL to_pulse_width got=%b exp=0", {bus.m_ack_o, bus.m_err_o}); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    set_master(2, 1'b0, 32'h5000_0000, 32'h0);
    tick();
    bus.s_ack_i   = 1'b1;
    bus.s_rdata_i = 32'h55;
    tick();
    bus.s_ack_i = 1'b0;
    bus.m_req_i = '0;
    tick(); // IDLE, rr_ptr = 3
    set_master(3, 1'b1, 32'h6000_0000, 32'h77);
    tick(); // BUSY, owner 3
    checks++; if (bus.grant_o !== 4'b1000) begin errors++; $display("FAIL ar_pre_grant got=%b exp=1000", bus.grant_o); end
    set_master(0, 1'b0, 32'h7000_0000, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    checks++; if ({bus.grant_o, bus.s_req_o, bus.s_we_o} !== 6'd0) begin errors++; $display("FAIL ar_async_clear got=%b exp=0", {bus.grant_o, bus.s_req_o, bus.s_we_o}); end
    checks++; if ({bus.m_rdata_o, bus.s_addr_o} !== 64'd0) begin errors++; $display("FAIL ar_async_data got=%h exp=0", {bus.m_rdata_o, bus.s_addr_o}); end
    checks++; if ({bus.hold_flag_rib_o, state} !== {1'b0, RIB_IDLE}) begin errors++; $display("FAIL ar_hold_state got=%b exp=0 idle", {bus.hold_flag_rib_o, state}); end
    bus.s_ack_i = 1'b1;
    tick();
    checks++; if ({bus.m_ack_o, bus.m_err_o} !== 8'd0) begin errors++; $display("FAIL ar_no_ack got=%b exp=0", {bus.m_ack_o, bus.m_err_o}); end
    bus.s_ack_i = 1'b0;
    rst = 1'b1; // masters 0 and 3 still requesting
    tick();
    checks++; if (bus.grant_o !== 4'b0001) begin errors++; $display("FAIL ar_first_grant got=%b exp=0001", bus.grant_o); end
    bus.s_ack_i = 1'b1;
    tick();
    bus.s_ack_i = 1'b0;
    bus.m_req_i = '0;
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_single_master();
    test_round_robin();
    test_hold_flag();
    test_ack_timeout_tie();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rib_arbiter.md
Name: rib_arbiter

Overview:
- Shares the single RIB slave bus between up to MASTERS requesters: core data port, core fetch port, JTAG debug, UART debug loader.
- Arbitration is round-robin. Each grant is locked for one whole transaction. A watchdog closes transactions that stall.
- Drives hold_flag_rib_o into the pipeline controller, so the core stalls its PC while its fetch or data port waits for the bus.
- Sits between the master ports and the slave address decoder.

Parameters:
- MASTERS, 4, number of requesters; index 0 = core data, 1 = core fetch.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles to wait for slave ack before an error response; minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- m_req_i  in  MASTERS  per-master request, held high until that master's m_ack_o.
- m_we_i  in  MASTERS  per-master write enable.
- m_addr_i  in  MASTERS*ADDR_W  flattened addresses; master k occupies [k*ADDR_W +: ADDR_W].
- m_wdata_i  in  MASTERS*DATA_W  flattened write data.
- m_ack_o  out  MASTERS  one-cycle completion pulse to the granted master.
- m_err_o  out  MASTERS  one-cycle timeout error pulse; coincides with m_ack_o.
- m_rdata_o  out  DATA_W  read data, shared; valid only with m_ack_o.
- s_req_o  out  1  slave request.
- s_we_o  out  1  slave write enable.
- s_addr_o  out  ADDR_W  slave address.
- s_wdata_o  out  DATA_W  slave write data.
- s_ack_i  in  1  slave completion.
- s_rdata_i  in  DATA_W  slave read data, valid with s_ack_i.
- grant_o  out  MASTERS  one-hot current owner; 0 when idle.
- hold_flag_rib_o  out  1  high while master 0 or 1 requests without holding the grant.

Behaviour:
- Reset (rst low, asynchronous): state = IDLE, rr_ptr = 0, wd_cnt = 0. Outputs: grant_o = 0, s_req_o = 0, s_we_o = 0, s_addr_o = 0, s_wdata_o = 0, m_ack_o = 0, m_err_o = 0, m_rdata_o = 0.
- Reset mid-transaction aborts it. No ack is issued. The slave sees s_req_o drop.
- States are IDLE, BUSY and RESP.
- IDLE:
  - With any m_req_i high, pick the first requester at or after rr_ptr, wrapping modulo MASTERS.
  - At the next edge, latch its we/addr/wdata into the s_* registers, set grant_o one-hot, set s_req_o = 1, and go to BUSY.
  - Grant latency is 1 cycle from request.
- BUSY:
  - s_* registers are frozen; a later change on a master's inputs is ignored.
  - wd_cnt increments each cycle.
  - s_ack_i = 1: latch s_rdata_i into m_rdata_o, pulse m_ack_o[owner], clear s_req_o, go to RESP.
  - wd_cnt == TIMEOUT-1 with no ack: m_rdata_o = 0, pulse m_ack_o[owner] and m_err_o[owner], clear s_req_o, go to RESP.
  - If ack and timeout occur in the same cycle, ack wins and m_err_o stays 0.
- RESP: lasts one cycle.
  - Clear grant_o, m_ack_o and m_err_o. Clear wd_cnt.
  - Set rr_ptr = (owner+1) mod MASTERS. Go to IDLE.
  - The master drops its req during RESP, so the next arbitration cannot re-grant a finished request.
- Throughput: at most one transaction per 3 cycles (IDLE, BUSY with same-cycle ack, RESP).
- Fairness: a continuously requesting master is granted within MASTERS transactions.
- hold_flag_rib_o is combinational: (m_req_i[0] & ~grant_o[0]) | (m_req_i[1] & ~grant_o[1]). It is 0 in reset.
- The arbiter stores only one-hot grant and a binary owner index; no other encoded state.
- A request that drops before being granted is simply skipped; there is no error.

Decomposition:
- Shared defines header: RIB_IDLE/RIB_BUSY/RIB_RESP state encodings, HoldEnable/HoldDisable, the RstEnable level (1'b0), and master index constants RIB_M_CORE_DATA = 0 and RIB_M_CORE_FETCH = 1.
- One sub-module, rr_pick: a combinational round-robin selector. Inputs are req and ptr; outputs are one-hot grant, binary index and valid.
- rr_pick is unit-tested separately.

Test Plan:
- Single master: m_req_i = 4'b0100, addr 0x1000_0004, read; s_ack_i asserted 3 cycles after s_req_o with rdata 0xDEAD_BEEF. Expect grant_o = 4'b0100 one cycle after req; m_ack_o[2] pulses with m_rdata_o = 0xDEAD_BEEF; return to IDLE.
- Round-robin: all four request continuously, immediate ack each time. Expect grant order 0,1,2,3,0; no master granted twice before all are served.
- Hold flag: master 3 in BUSY while master 1 raises req. Expect hold_flag_rib_o = 1 until grant_o = 4'b0010, then 0.
- Timeout: TIMEOUT = 8, slave never acks. Expect m_ack_o and m_err_o pulse together after exactly 8 BUSY cycles, with m_rdata_o = 0.
- Ack/timeout tie: s_ack_i arrives in the last watchdog cycle. Expect m_err_o = 0 and rdata passed through.
- Async reset: assert rst low mid-BUSY. Expect all outputs 0 immediately, no ack pulse, and after release the first grant goes to master 0 (rr_ptr = 0).
